pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised multi-cycle program-counter and phase sequencer for the RISC-V core, replacing the fixed free-running 5-count PC logic. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and stalls on memory handshakes. It contains a correct signed/unsigned branch comparator and raises a sticky trap on misaligned control-flow targets. It sits between the control unit, ALU, register file, ROM and RAM, and drives the instruction address and phase strobes.

## Interface
- XLEN, 32, datapath and PC width
- RESET_VECTOR, 0, PC value after reset
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- is_mem  in  1  current instruction accesses RAM (load/store)
- is_branch  in  1  conditional branch
- is_jump  in  1  JAL/JALR, always taken
- br_funct3  in  3  RV32I branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- rs1_val, rs2_val  in  XLEN  register operands
- target  in  XLEN  ALU-computed branch/jump target
- halt_req  in  1  stop after the current instruction retires
- pc  out  XLEN  current instruction address
- phase  out  3  current phase encoding
- imem_req, dmem_req  out  1  memory request strobes
- wb_en  out  1  register-file write strobe, one cycle per instruction
- br_eq, br_lt  out  1  registered comparator results
- br_taken  out  1  registered take decision
- trap  out  1  sticky misaligned-target trap
- halted  out  1  sequencer parked
- retired  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, TRAP.
- FETCH:
  - imem_req=1.
  - Stays in FETCH until imem_ready is sampled high, then goes to DECODE.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: one cycle.
  - Registers br_eq = (rs1_val==rs2_val).
  - Registers br_lt as signed or unsigned, per br_funct3 bit 1 (set means unsigned).
  - br_taken = is_jump | (is_branch & cond). cond is eq, !eq, lt or !lt, per funct3.
  - Next state is MEM if is_mem, else WRITEBACK.
- MEM:
  - dmem_req=1.
  - Stays in MEM until dmem_ready is sampled high, then goes to WRITEBACK.
- WRITEBACK:
  - wb_en=1 for exactly this cycle; retired increments, wrapping modulo 2^CNT_W.
  - pc becomes target if br_taken, else pc+4, truncated to XLEN.
  - Next state is HALTED if halt_req, else FETCH.
- Trap check:
  - In WRITEBACK, if br_taken and target[1:0]!=0, go to TRAP instead.
  - In that case pc is unchanged, wb_en=0 and retired is unchanged.
  - Trap has priority over halt_req.
- TRAP: trap=1. The state is left only by reset.
- HALTED:
  - halted=1, all strobes 0.
  - Returns to FETCH on the first cycle halt_req is sampled low; pc is preserved.
- Undefined br_funct3 values (010, 011): cond=0.

## Timing
- Reset (rst low at a clock edge) takes priority over every state, including mid-stall and TRAP. Reset values:
  - pc=RESET_VECTOR, phase=FETCH.
  - imem_req=1 on the first cycle after reset; dmem_req=0, wb_en=0.
  - br_eq=br_lt=br_taken=0, trap=0, halted=0, retired=0.
- Phase strobes are Moore outputs, decoded from state only.
- Minimum instruction latency with ready signals held high:
  - 4 cycles for non-memory instructions.
  - 5 cycles for memory instructions.
- A ready signal asserted outside its matching phase is ignored.
- pc and retired update on the same edge that leaves WRITEBACK.

## Structure
- Shared package cpu_pkg holds:
  - the phase_t enum: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALTED=5, TRAP=6;
  - the funct3 branch constants.
- One combinational sub-module, branch_cmp: XLEN-parametrised eq/lt with an unsigned select. The sequencer instantiates it and registers its outputs.

## Test plan
- Reset then imem_ready=1, is_mem=0, no branch:
  - phase cycles 0,1,2,4,0.
  - pc 0→4 after 4 cycles; retired=1; one wb_en pulse.
- Load with dmem_ready delayed 3 cycles:
  - dmem_req held for 4 cycles.
  - Instruction takes 8 cycles; pc=4.
- BLT with rs1=0xFFFFFFFF, rs2=1, target=0x40: br_lt=1, br_taken=1, pc=0x40.
- Same operands with BLTU: br_lt=0, pc=4.
- JAL with target=0x42:
  - enters TRAP; trap=1, pc unchanged, retired unchanged.
  - Stays in TRAP for 10 cycles; rst low clears it.
- halt_req high during WRITEBACK, then low 5 cycles later:
  - halted=1 for those cycles.
  - Then FETCH resumes at pc+4.
  - rst low mid-stall in FETCH returns pc to RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared phase encoding and RV32I branch funct3 decode for the core.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5,
    TRAP      = 3'd6
  } phase_t;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  // funct3 010/011 are not branches in RV32I and never take.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       eq,
                                       input logic       lt);
    logic result;
    result = 1'b0;
    case (funct3)
      c_f3_beq:  result = eq;
      c_f3_bne:  result = !eq;
      c_f3_blt:  result = lt;
      c_f3_bge:  result = !lt;
      c_f3_bltu: result = lt;
      c_f3_bgeu: result = !lt;
      default:   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cmp                                                           |
// | Combinational equality and signed/unsigned less-than comparator.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_unsigned,
  output logic            eq,
  output logic            lt
);

  always_comb begin
    eq = (a == b);
    if (is_unsigned) lt = (a < b);
    else             lt = ($signed(a) < $signed(b));
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer                                                         |
// | Multi-cycle PC / phase sequencer with branch resolve and trap.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             is_mem,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  target,
  input  logic             halt_req,
  output logic [XLEN-1:0]  pc,
  output logic [2:0]       phase,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             wb_en,
  output logic             br_eq,
  output logic             br_lt,
  output logic             br_taken,
  output logic             trap,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  phase_t            r_state;
  phase_t            w_next;
  logic [XLEN-1:0]   r_pc;
  logic [CNT_W-1:0]  r_retired;
  logic              r_br_eq;
  logic              r_br_lt;
  logic              r_br_taken;
  logic              w_eq;
  logic              w_lt;
  logic              w_trap_hit;
  logic              w_retire;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a           (rs1_val),
    .b           (rs2_val),
    .is_unsigned (br_funct3[1]),
    .eq          (w_eq),
    .lt          (w_lt)
  );

  // A taken transfer to a non-word-aligned target aborts the retire.
  assign w_trap_hit = r_br_taken && (target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    w_retire = 1'b0;
    trap     = 1'b0;
    halted   = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) w_next = DECODE;
      end
      DECODE:  w_next = EXECUTE;
      EXECUTE: w_next = is_mem ? MEM : WRITEBACK;
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) w_next = WRITEBACK;
      end
      WRITEBACK: begin
        if (w_trap_hit) begin
          w_next = TRAP;
        end else begin
          w_retire = 1'b1;
          w_next   = halt_req ? HALTED : FETCH;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (!halt_req) w_next = FETCH;
      end
      TRAP: begin
        trap   = 1'b1;
        w_next = TRAP;
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_VECTOR;
      r_retired  <= '0;
      r_br_eq    <= 1'b0;
      r_br_lt    <= 1'b0;
      r_br_taken <= 1'b0;
    end else begin
      if (r_state == EXECUTE) begin
        r_br_eq    <= w_eq;
        r_br_lt    <= w_lt;
        r_br_taken <= is_jump | (is_branch & branch_cond(br_funct3, w_eq, w_lt));
      end
      if (w_retire) begin
        r_pc      <= r_br_taken ? target : (r_pc + XLEN'(4));
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign pc       = r_pc;
  assign phase    = r_state;
  assign wb_en    = w_retire;
  assign br_eq    = r_br_eq;
  assign br_lt    = r_br_lt;
  assign br_taken = r_br_taken;
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_sequencer                                                      |
// | Randomised per-instruction bench with a cycle-by-cycle expected trace.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [2:0] P_FETCH = 3'd0, P_DECODE = 3'd1, P_EXEC = 3'd2,
                         P_MEM = 3'd3, P_WB = 3'd4, P_HALT = 3'd5, P_TRAP = 3'd6;

  typedef struct packed {
    logic [2:0]  phase;
    logic        imem_req, dmem_req, wb_en, br_eq, br_lt, br_taken, trap, halted;
    logic [31:0] pc;
    logic [31:0] retired;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ready = 0, dmem_ready = 0, is_mem = 0, is_branch = 0, is_jump = 0;
  logic [2:0]  br_funct3 = 0;
  logic [31:0] rs1_val = 0, rs2_val = 0, target = 0;
  logic        halt_req = 0;
  logic [31:0] pc;
  logic [2:0]  phase;
  logic        imem_req, dmem_req, wb_en, br_eq, br_lt, br_taken, trap, halted;
  logic [31:0] retired;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_mem(is_mem), .is_branch(is_branch), .is_jump(is_jump), .br_funct3(br_funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .target(target), .halt_req(halt_req),
    .pc(pc), .phase(phase), .imem_req(imem_req), .dmem_req(dmem_req), .wb_en(wb_en),
    .br_eq(br_eq), .br_lt(br_lt), .br_taken(br_taken), .trap(trap), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0;
  int   n_wb = 0, n_dmem = 0, n_halt = 0;
  obs_t expq[$];

  // Reference model: architectural state only, advanced per instruction.
  logic [31:0] m_pc = 0, m_ret = 0;
  logic        m_eq = 0, m_lt = 0, m_tk = 0, m_trapped = 0;

  function automatic obs_t mk(input logic [2:0] ph, input logic wb);
    obs_t o;
    o.phase = ph;       o.imem_req = (ph == P_FETCH); o.dmem_req = (ph == P_MEM);
    o.wb_en = wb;       o.br_eq = m_eq; o.br_lt = m_lt; o.br_taken = m_tk;
    o.trap = (ph == P_TRAP); o.halted = (ph == P_HALT);
    o.pc = m_pc;        o.retired = m_ret;
    return o;
  endfunction

  always @(negedge clk) begin
    obs_t e, a;
    if (wb_en) n_wb++;
    if (dmem_req) n_dmem++;
    if (halted) n_halt++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.phase = phase; a.imem_req = imem_req; a.dmem_req = dmem_req; a.wb_en = wb_en;
      a.br_eq = br_eq; a.br_lt = br_lt; a.br_taken = br_taken; a.trap = trap;
      a.halted = halted; a.pc = pc; a.retired = retired;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL trace t=%0t got ph=%0d im=%b dm=%b wb=%b eq=%b lt=%b tk=%b tr=%b hl=%b pc=%h ret=%0d want ph=%0d im=%b dm=%b wb=%b eq=%b lt=%b tk=%b tr=%b hl=%b pc=%h ret=%0d",
                 $time, a.phase, a.imem_req, a.dmem_req, a.wb_en, a.br_eq, a.br_lt, a.br_taken,
                 a.trap, a.halted, a.pc, a.retired, e.phase, e.imem_req, e.dmem_req, e.wb_en,
                 e.br_eq, e.br_lt, e.br_taken, e.trap, e.halted, e.pc, e.retired);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle(input obs_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_ready = 0; dmem_ready = 0; halt_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_pc = 0; m_ret = 0; m_eq = 0; m_lt = 0; m_tk = 0; m_trapped = 0;
  endtask

  // hh < 0: no halt; otherwise halt_req stays high hh cycles into HALTED.
  task automatic run_instr(input logic mem, input logic br, input logic jmp,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] tgt, input int di, input int dd, input int hh);
    logic cond, mis;
    is_mem = mem; is_branch = br; is_jump = jmp; br_funct3 = f3;
    rs1_val = a; rs2_val = b; target = tgt; halt_req = 0;
    for (int k = 0; k <= di; k++) begin
      imem_ready = (k == di); dmem_ready = 1'($urandom);
      cycle(mk(P_FETCH, 1'b0));
    end
    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
    cycle(mk(P_DECODE, 1'b0));
    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
    cycle(mk(P_EXEC, 1'b0));
    m_eq = (a == b);
    m_lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    case (f3)
      3'b000: cond = m_eq;
      3'b001: cond = !m_eq;
      3'b100, 3'b110: cond = m_lt;
      3'b101, 3'b111: cond = !m_lt;
      default: cond = 1'b0;
    endcase
    m_tk = jmp | (br & cond);
    if (mem) begin
      for (int k = 0; k <= dd; k++) begin
        dmem_ready = (k == dd); imem_ready = 1'($urandom);
        cycle(mk(P_MEM, 1'b0));
      end
    end
    mis = m_tk && (tgt[1:0] != 2'b00);
    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
    halt_req = (hh >= 0) || (mis && 1'($urandom));
    cycle(mk(P_WB, !mis));
    if (mis) begin
      m_trapped = 1'b1;
    end else begin
      m_pc  = m_tk ? tgt : m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
      if (hh >= 0) begin
        for (int k = 0; k < hh; k++) begin
          halt_req = 1'b1; imem_ready = 1'($urandom);
          cycle(mk(P_HALT, 1'b0));
        end
        halt_req = 1'b0;
        cycle(mk(P_HALT, 1'b0));
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic trap_and_reset();
    for (int k = 0; k < 10; k++) begin
      halt_req = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      cycle(mk(P_TRAP, 1'b0));
    end
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, h0, hh, kind;
    logic [31:0] a, b, t;
    logic [2:0]  f3;

    @(posedge clk); #1;
    do_reset();
    check("reset_pc", pc, 32'h0);
    check("reset_phase", {29'b0, phase}, 32'h0);
    check("reset_imem_req", {31'b0, imem_req}, 32'h1);
    check("reset_misc", {26'b0, dmem_req, wb_en, br_eq, br_lt, br_taken, trap}, 32'h0);

    // Plain ALU instruction.
    w0 = n_wb;
    run_instr(0, 0, 0, 3'b000, 32'h5, 32'h7, 32'h100, 0, 0, -1);
    check("alu_pc", pc, 32'h4);
    check("alu_retired", retired, 32'h1);
    check("alu_wb_pulses", n_wb - w0, 1);
    check("model_pc", m_pc, 32'h4);

    // Load with dmem_ready three cycles late.
    do_reset();
    d0 = n_dmem;
    run_instr(1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 3, -1);
    check("load_pc", pc, 32'h4);
    check("load_dmem_cycles", n_dmem - d0, 4);

    // BLT signed: -1 < 1.
    do_reset();
    run_instr(0, 1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h40, 0, 0, -1);
    check("blt_br_lt", {31'b0, br_lt}, 32'h1);
    check("blt_taken", {31'b0, br_taken}, 32'h1);
    check("blt_pc", pc, 32'h40);

    // BLTU: 0xFFFFFFFF is not below 1.
    do_reset();
    run_instr(0, 1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h40, 0, 0, -1);
    check("bltu_br_lt", {31'b0, br_lt}, 32'h0);
    check("bltu_pc", pc, 32'h4);

    // JAL to a misaligned target.
    do_reset();
    run_instr(0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h42, 0, 0, -1);
    check("jal_trap", {31'b0, trap}, 32'h1);
    check("jal_pc", pc, 32'h0);
    check("jal_retired", retired, 32'h0);
    trap_and_reset();
    check("trap_cleared", {31'b0, trap}, 32'h0);

    // Halt during writeback, released five cycles later.
    do_reset();
    h0 = n_halt;
    run_instr(0, 0, 0, 3'b000, 32'h1, 32'h2, 32'h0, 1, 0, 4);
    check("halt_cycles", n_halt - h0, 5);
    check("halt_resume_pc", pc, 32'h4);
    check("halt_resume_phase", {29'b0, phase}, {29'b0, P_FETCH});
    run_instr(0, 0, 0, 3'b000, 32'h1, 32'h2, 32'h0, 0, 0, -1);
    check("after_halt_pc", pc, 32'h8);

    // Reset in the middle of a fetch stall.
    imem_ready = 0;
    for (int k = 0; k < 3; k++) cycle(mk(P_FETCH, 1'b0));
    do_reset();
    check("midstall_pc", pc, 32'h0);
    check("midstall_retired", retired, 32'h0);

    // Randomised instruction stream.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 2) == 0) b = {~a[31], b[30:0]};
      f3 = 3'($urandom);
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
      hh = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      run_instr(kind == 1, kind == 2, kind == 3, f3, a, b, t,
                $urandom_range(0, 3), $urandom_range(0, 3), hh);
      if (m_trapped) trap_and_reset();
    end

    cycle(mk(P_FETCH, 1'b0));
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
